// File: rtl/mips_dmem_pkg.sv
// Shared definitions for the MIPS data-memory arbiter.
//   state_e  : arbiter FSM states (IDLE -> ISSUE -> WAIT -> DONE -> IDLE)
//   REQ_CPU  : requester id of the core load/store port
//   REQ_DMA  : requester id of the loader/DMA port
//   PERF_W   : width of the optional performance counters
//   sat_inc  : saturating increment used by those counters
package mips_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int PERF_W = 16;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    if (v == {PERF_W{1'b1}}) begin
      return v;
    end
    return v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
//   req_i[0]    : CPU request
//   req_i[1]    : DMA request
//   last_gnt_i  : id of the requester served most recently
//   gnt_id_o    : id of the winner (REQ_CPU / REQ_DMA)
//   gnt_valid_o : at least one request is present
// A single requester always wins; when both request, the one that was
// not served last wins.
module rr_arb2
  import mips_dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_id_o,
  output logic       gnt_valid_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = REQ_CPU;
    case (req_i)
      2'b01:   gnt_id_o = REQ_CPU;
      2'b10:   gnt_id_o = REQ_DMA;
      2'b11:   gnt_id_o = ~last_gnt_i;
      default: gnt_id_o = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Shares the single-port MIPS data memory between the core load/store port
// (CPU) and the loader/DMA port. One access at a time: the winner's fields
// are latched, strobed to memory for one cycle, the fixed memory latency is
// waited out, then a one-cycle ack is returned to the winner.
//
// Parameters:
//   ADDR_W  : byte address width (passed through unchanged)
//   DATA_W  : data word width
//   MEM_LAT : cycles from mem_en_o to valid mem_rdata_i (>= 1)
//
// Ports:
//   clk_i, rst_ni                 : clock (rising edge), async active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i : CPU request and fields
//   cpu_stall_o                   : cpu_req_i & ~cpu_ack_o
//   cpu_ack_o, cpu_rdata_o        : completion pulse and load data
//   dma_req_i/we_i/addr_i/wdata_i : loader request and fields
//   dma_ack_o, dma_rdata_o        : completion pulse and load data
//   mem_en_o/we_o/addr_o/wdata_o  : memory strobe and fields
//   mem_rdata_i                   : memory read data
//   perf_*_cnt_o                  : only with DMEM_ARB_PERF_EN defined
//   state_o                       : current FSM state (debug)
//
// Handshake: a requester raises req with fields stable and keeps them until
// it sees its one-cycle ack; the ack cycle is the only completion indication
// and load data is valid only while ack is high.
//
// Build option: define DMEM_ARB_PERF_EN to add the saturating performance
// counters (completed accesses per requester, IDLE cycles with a conflict).
module mips_dmem_arbiter
  import mips_dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // CPU port
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_stall_o,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  // DMA / loader port
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  // Data memory
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef DMEM_ARB_PERF_EN
  output logic [PERF_W-1:0] perf_cpu_cnt_o,
  output logic [PERF_W-1:0] perf_dma_cnt_o,
  output logic [PERF_W-1:0] perf_conflict_cnt_o,
`endif
  // Debug
  output state_e            state_o
);

  // Wide enough to hold MEM_LAT itself.
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  state_e              state_q,     state_d;
  logic                gnt_q,       gnt_d;
  logic                last_gnt_q,  last_gnt_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                dma_ack_q,   dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

  logic                arb_id;
  logic                arb_valid;

  rr_arb2 u_rr_arb2 (
    .req_i       ({dma_req_i, cpu_req_i}),
    .last_gnt_i  (last_gnt_q),
    .gnt_id_o    (arb_id),
    .gnt_valid_o (arb_valid)
  );

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      IDLE: begin
        // Requests are only looked at here; anything raised while busy
        // simply waits for the next IDLE cycle.
        if (arb_valid) begin
          gnt_d = arb_id;
          if (arb_id == REQ_DMA) begin
            mem_we_d    = dma_we_i;
            mem_addr_d  = dma_addr_i;
            mem_wdata_d = dma_wdata_i;
          end else begin
            mem_we_d    = cpu_we_i;
            mem_addr_d  = cpu_addr_i;
            mem_wdata_d = cpu_wdata_i;
          end
          // Registered strobe: high during the ISSUE cycle only.
          mem_en_d = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end

      WAIT: begin
        // The counter starts at MEM_LAT, so the last WAIT cycle is exactly
        // MEM_LAT cycles after the strobe, when mem_rdata_i is valid.
        if (cnt_q == CNT_W'(1)) begin
          cnt_d = '0;
          if (gnt_q == REQ_DMA) begin
            dma_ack_d = 1'b1;
            if (!mem_we_q) begin
              dma_rdata_d = mem_rdata_i;
            end
          end else begin
            cpu_ack_d = 1'b1;
            if (!mem_we_q) begin
              cpu_rdata_d = mem_rdata_i;
            end
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        // Ack is on this cycle; record the winner for the next tie.
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_q       <= REQ_CPU;
      last_gnt_q  <= REQ_DMA;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // ---------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------
  logic [PERF_W-1:0] perf_cpu_q,  perf_cpu_d;
  logic [PERF_W-1:0] perf_dma_q,  perf_dma_d;
  logic [PERF_W-1:0] perf_conf_q, perf_conf_d;

  always_comb begin
    perf_cpu_d  = perf_cpu_q;
    perf_dma_d  = perf_dma_q;
    perf_conf_d = perf_conf_q;
    // An access counts as completed in its DONE (ack) cycle.
    if (state_q == DONE) begin
      if (gnt_q == REQ_DMA) begin
        perf_dma_d = sat_inc(perf_dma_q);
      end else begin
        perf_cpu_d = sat_inc(perf_cpu_q);
      end
    end
    if ((state_q == IDLE) && cpu_req_i && dma_req_i) begin
      perf_conf_d = sat_inc(perf_conf_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cpu_q  <= '0;
      perf_dma_q  <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_cpu_q  <= perf_cpu_d;
      perf_dma_q  <= perf_dma_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_cpu_cnt_o      = perf_cpu_q;
  assign perf_dma_cnt_o      = perf_dma_q;
  assign perf_conflict_cnt_o = perf_conf_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_ack_o   = dma_ack_q;
  assign dma_rdata_o = dma_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// Self-checking bench for mips_dmem_arbiter (MEM_LAT = 1).
// A transaction-level model schedules each access as arithmetic on cycle
// numbers (decision cycle N -> strobe N+1 -> ack N+LAT+2 -> free N+LAT+3)
// and a reference memory supplies expected load data. Directed tests add
// hand-computed latency/data/ordering expectations.
module tb_mips_dmem_arbiter;
  import mips_dmem_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          cpu_req, cpu_we, cpu_stall, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  state_e        state;
`ifdef DMEM_ARB_PERF_EN
  logic [PERF_W-1:0] perf_cpu, perf_dma, perf_conf;
`endif

  mips_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_stall_o  (cpu_stall),
    .cpu_ack_o    (cpu_ack),
    .cpu_rdata_o  (cpu_rdata),
    .dma_req_i    (dma_req),
    .dma_we_i     (dma_we),
    .dma_addr_i   (dma_addr),
    .dma_wdata_i  (dma_wdata),
    .dma_ack_o    (dma_ack),
    .dma_rdata_o  (dma_rdata),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
`ifdef DMEM_ARB_PERF_EN
    .perf_cpu_cnt_o      (perf_cpu),
    .perf_dma_cnt_o      (perf_dma),
    .perf_conflict_cnt_o (perf_conf),
`endif
    .state_o      (state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memories ----------------
  logic [DW-1:0] env_mem [64];   // the memory the DUT really talks to
  logic [DW-1:0] ref_mem [64];   // model's view of memory contents
  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
  end

  // Memory environment: sample the strobe mid-cycle, return load data in the
  // following cycle (LAT = 1); otherwise drive recognisable garbage.
  initial begin : mem_env
    logic          pend;
    logic [DW-1:0] pdata;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      pdata = '0;
      if (rst_n && mem_en === 1'b1) begin
        if (mem_we) env_mem[mem_addr[7:2]] = mem_wdata;
        else begin
          pend  = 1'b1;
          pdata = env_mem[mem_addr[7:2]];
        end
      end
      @(posedge clk);
      #1;
      mem_rdata = pend ? pdata : (32'hBAD0_0000 + cyc);
    end
  end

  // ---------------- transaction-level model ----------------
  int            busy_until = 0;
  int            issue_cyc  = -1;
  int            ack_cyc    = -1;
  logic          win        = REQ_CPU;
  logic          win_we     = 1'b0;
  logic [AW-1:0] win_addr   = '0;
  logic [DW-1:0] win_wdata  = '0;
  logic [DW-1:0] win_rdata  = '0;
  logic          last_gnt   = REQ_DMA;
  logic [DW-1:0] m_cpu_rdata = '0;
  logic [DW-1:0] m_dma_rdata = '0;
  int            m_cpu_done = 0, m_dma_done = 0, m_conf = 0;
  int            cpu_ack_cycs[$];
  int            dma_ack_cycs[$];

  initial begin : compare
    logic exp_en, exp_cack, exp_dack, both;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_mem_en",    mem_en,    0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_ack",   cpu_ack,   0);
        chk("rst_dma_ack",   dma_ack,   0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_cpu_stall", cpu_stall, cpu_req);
        busy_until = 0; issue_cyc = -1; ack_cyc = -1;
        last_gnt = REQ_DMA; m_cpu_rdata = '0; m_dma_rdata = '0;
        m_cpu_done = 0; m_dma_done = 0; m_conf = 0;
      end else begin
        exp_en   = (cyc == issue_cyc);
        exp_cack = (cyc == ack_cyc) && (win == REQ_CPU);
        exp_dack = (cyc == ack_cyc) && (win == REQ_DMA);
        chk("mem_en",    mem_en,    exp_en);
        chk("cpu_ack",   cpu_ack,   exp_cack);
        chk("dma_ack",   dma_ack,   exp_dack);
        chk("cpu_stall", cpu_stall, cpu_req & ~exp_cack);
        if (exp_en) begin
          chk("mem_we",    mem_we,    win_we);
          chk("mem_addr",  mem_addr,  win_addr);
          chk("mem_wdata", mem_wdata, win_wdata);
        end
        if (exp_cack) chk("cpu_rdata", cpu_rdata, win_we ? m_cpu_rdata : win_rdata);
        if (exp_dack) chk("dma_rdata", dma_rdata, win_we ? m_dma_rdata : win_rdata);
        if (cpu_ack === 1'b1) cpu_ack_cycs.push_back(cyc);
        if (dma_ack === 1'b1) dma_ack_cycs.push_back(cyc);
        // Completion: remember who was served and what a load returned.
        if (cyc == ack_cyc) begin
          last_gnt = win;
          if (win == REQ_CPU) begin
            m_cpu_done++;
            if (!win_we) m_cpu_rdata = win_rdata;
          end else begin
            m_dma_done++;
            if (!win_we) m_dma_rdata = win_rdata;
          end
        end
        // New decision when the memory is free.
        if (cyc >= busy_until && (cpu_req || dma_req)) begin
          both = cpu_req && dma_req;
          if (both) m_conf++;
          win = both ? ~last_gnt : (dma_req ? REQ_DMA : REQ_CPU);
          win_we    = (win == REQ_DMA) ? dma_we    : cpu_we;
          win_addr  = (win == REQ_DMA) ? dma_addr  : cpu_addr;
          win_wdata = (win == REQ_DMA) ? dma_wdata : cpu_wdata;
          if (win_we) ref_mem[win_addr[7:2]] = win_wdata;
          else        win_rdata = ref_mem[win_addr[7:2]];
          issue_cyc  = cyc + 1;
          ack_cyc    = cyc + LAT + 2;
          busy_until = cyc + LAT + 3;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue n consecutive accesses; req stays high between them. Returns the
  // latency (request cycle to ack cycle) of the first one and the last rdata.
  task automatic cpu_run(input int n, input logic we, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, output logic [DW-1:0] rd, output int lat0);
    int  start;
    bit  got;
    lat0 = -1;
    rd   = '0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a0 + 4 * i; cpu_wdata = d0 + i;
      start = cyc;
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (cpu_ack === 1'b1) got = 1;
      end
      if (!got) chk("cpu_ack_timeout", 0, 1);
      rd = cpu_rdata;
      if (i == 0) lat0 = cyc - start;
      @(posedge clk); #1;
    end
    cpu_req = 1'b0;
  endtask

  task automatic dma_run(input int n, input logic we, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, output logic [DW-1:0] rd, output int lat0);
    int  start;
    bit  got;
    lat0 = -1;
    rd   = '0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      dma_req = 1'b1; dma_we = we; dma_addr = a0 + 4 * i; dma_wdata = d0 + i;
      start = cyc;
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge clk);
        if (dma_ack === 1'b1) got = 1;
      end
      if (!got) chk("dma_ack_timeout", 0, 1);
      rd = dma_rdata;
      if (i == 0) lat0 = cyc - start;
      @(posedge clk); #1;
    end
    dma_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    logic [DW-1:0] rd_c, rd_d;
    int            lat_c, lat_d, a0, ndma;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;

    // 1: reset ~20 ns, then idle
    #1 rst_n = 1'b0;
    #21 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("t1_idle_state", state, IDLE);

    // 2: CPU store 25 to 0x4, ack three cycles after the request
    cpu_run(1, 1'b1, 32'h4, 32'd25, rd_c, lat_c);
    chk("t2_store_latency", lat_c, 3);

    // 3: CPU load from 0x4 returns 25
    cpu_run(1, 1'b0, 32'h4, 32'd0, rd_c, lat_c);
    chk("t3_load_latency", lat_c, 3);
    chk("t3_load_rdata", rd_c, 32'd25);

    // DMA store then CPU load across ports; a later CPU store keeps old rdata
    dma_run(1, 1'b1, 32'h8, 32'h55AA, rd_d, lat_d);
    chk("t3b_dma_store_latency", lat_d, 3);
    cpu_run(1, 1'b0, 32'h8, 32'd0, rd_c, lat_c);
    chk("t3b_cross_rdata", rd_c, 32'h55AA);
    cpu_run(1, 1'b1, 32'h10, 32'h77, rd_c, lat_c);
    chk("t3b_store_holds_rdata", rd_c, 32'h55AA);
    dma_run(1, 1'b0, 32'h14, 32'd0, rd_d, lat_d);
    chk("t3b_dma_load_rdata", rd_d, 32'h1000_0005);

    // 4: first tie after reset goes to CPU, then strict alternation
    pulse_reset();
    cpu_ack_cycs.delete();
    dma_ack_cycs.delete();
    fork
      cpu_run(2, 1'b0, 32'h20, 32'd0, rd_c, lat_c);
      dma_run(2, 1'b1, 32'h30, 32'h70, rd_d, lat_d);
    join
    chk("t4_cpu_first_latency", lat_c, 3);
    chk("t4_dma_first_latency", lat_d, 7);
    chk("t4_cpu_acks", cpu_ack_cycs.size(), 2);
    chk("t4_dma_acks", dma_ack_cycs.size(), 2);
    if (cpu_ack_cycs.size() == 2 && dma_ack_cycs.size() == 2) begin
      a0 = cpu_ack_cycs[0];
      chk("t4_dma_ack0", dma_ack_cycs[0], a0 + 4);
      chk("t4_cpu_ack1", cpu_ack_cycs[1], a0 + 8);
      chk("t4_dma_ack1", dma_ack_cycs[1], a0 + 12);
    end
    chk("t4_cpu_load_rdata", rd_c, 32'h1000_0009);

    // 5: reset while a DMA load waits for memory -> no ack, clean restart
    ndma = dma_ack_cycs.size();
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h8;
    @(posedge clk); #1;                   // ISSUE
    @(posedge clk); #1;                   // WAIT
    chk("t5_in_wait", state, WAIT);
    rst_n = 1'b0;
    dma_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    chk("t5_state_idle", state, IDLE);
    repeat (3) @(posedge clk);
    chk("t5_no_dma_ack", dma_ack_cycs.size(), ndma);
    cpu_run(1, 1'b0, 32'h8, 32'd0, rd_c, lat_c);
    chk("t5_cpu_latency", lat_c, 3);
    chk("t5_cpu_rdata", rd_c, 32'h55AA);

`ifdef DMEM_ARB_PERF_EN
    // 6: 3 CPU + 2 DMA accesses starting with a tie
    pulse_reset();
    fork
      cpu_run(3, 1'b0, 32'h40, 32'd0, rd_c, lat_c);
      dma_run(2, 1'b0, 32'h50, 32'd0, rd_d, lat_d);
    join
    @(negedge clk);
    chk("t6_perf_cpu", perf_cpu, 3);
    chk("t6_perf_dma", perf_dma, 2);
    chk("t6_perf_conflict_min", (perf_conf >= 1), 1);
    chk("t6_perf_conflict_model", perf_conf, m_conf);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
